// File: rtl/display_pkg.sv
// Shared definitions for the display scheduler.
//   state_t      : FSM encoding, also exported on the debug `state` port
//   SEL_TL/DICE  : values driven on the mux select
//   *_DEF        : default slot lengths and slot-counter width
package display_pkg;

    typedef enum logic [1:0] {
        S_TL    = 2'b00,   // traffic lights shown, auto slice running
        S_DICE  = 2'b01,   // dice shown, auto slice running
        S_HOLD  = 2'b10,   // dice shown because of a button press
        S_FORCE = 2'b11    // traffic lights locked by force_tl
    } state_t;

    localparam logic SEL_TL   = 1'b1;
    localparam logic SEL_DICE = 1'b0;

    localparam int TL_SLOT_DEF   = 16;
    localparam int DICE_SLOT_DEF = 8;
    localparam int HOLD_DEF      = 4;
    localparam int CW_DEF        = 8;

endpackage

// File: rtl/slot_timer.sv
// Slot counter for the display scheduler.
//   clk   : system clock, rising edge
//   rst   : asynchronous, active-low reset (count returns to 0)
//   clr   : synchronous clear, takes priority over en
//   en    : advance the count by one
//   limit : current slot length in cycles (>= 1)
//   done  : high while the count sits on the last cycle of the slot
module slot_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] limit,
    output logic          done
);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign done = (cnt_reg == (limit - CW'(1)));

endmodule

// File: rtl/display_scheduler.sv
// Owns the select line of the dice / traffic-light display mux.
//   clk         : system clock, rising edge
//   rst         : asynchronous, active-low reset
//   button_in   : roll request (synchronous, debounced upstream)
//   auto_en     : 1 = time-slice between views, 0 = traffic lights unless button
//   force_tl    : lock display on traffic lights, block the dice
//   sel         : mux select, 1 = traffic lights, 0 = dice
//   dice_button : button forwarded to the dice roller, only while dice is visible
//   switch      : one-cycle pulse on the cycle sel changes
//   state       : current FSM state for debug LEDs
module display_scheduler
    import display_pkg::*;
#(
    parameter int TL_SLOT   = TL_SLOT_DEF,
    parameter int DICE_SLOT = DICE_SLOT_DEF,
    parameter int HOLD      = HOLD_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_in,
    input  logic       auto_en,
    input  logic       force_tl,
    output logic       sel,
    output logic       dice_button,
    output logic       switch,
    output logic [1:0] state
);

    state_t        state_reg, state_next;
    logic          sel_reg, sel_next;
    logic          dice_button_reg;
    logic          switch_reg;
    logic          tmr_clr, tmr_en, tmr_done;
    logic [CW-1:0] tmr_limit;

    // The slot length follows the state we are currently timing.
    always_comb begin
        case (state_reg)
            S_DICE:  tmr_limit = CW'(DICE_SLOT);
            S_HOLD:  tmr_limit = CW'(HOLD);
            default: tmr_limit = CW'(TL_SLOT);
        endcase
    end

    slot_timer #(
        .CW (CW)
    ) u_slot_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_TL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Priority order in every state: force_tl, button_in, slot expiry, auto_en.
    // The counter is cleared on every state change so each slice starts at 0.
    always_comb begin
        state_next = state_reg;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        case (state_reg)
            S_TL: begin
                if (force_tl) begin
                    state_next = S_FORCE;
                    tmr_clr    = 1'b1;
                end else if (button_in) begin
                    state_next = S_HOLD;
                    tmr_clr    = 1'b1;
                end else if (auto_en && tmr_done) begin
                    state_next = S_DICE;
                    tmr_clr    = 1'b1;
                end else if (auto_en) begin
                    tmr_en     = 1'b1;
                end else begin
                    tmr_clr    = 1'b1;   // manual mode: keep the slice parked at 0
                end
            end
            S_DICE: begin
                if (force_tl) begin
                    state_next = S_FORCE;
                    tmr_clr    = 1'b1;
                end else if (button_in) begin
                    state_next = S_HOLD;
                    tmr_clr    = 1'b1;
                end else if (!auto_en || tmr_done) begin
                    state_next = S_TL;
                    tmr_clr    = 1'b1;
                end else begin
                    tmr_en     = 1'b1;
                end
            end
            S_HOLD: begin
                if (force_tl) begin
                    state_next = S_FORCE;
                    tmr_clr    = 1'b1;
                end else if (button_in) begin
                    tmr_clr    = 1'b1;   // hold time counts from release
                end else if (tmr_done) begin
                    state_next = S_TL;   // always back to lights, auto or not
                    tmr_clr    = 1'b1;
                end else begin
                    tmr_en     = 1'b1;
                end
            end
            default: begin   // S_FORCE
                tmr_clr = 1'b1;
                if (!force_tl) begin
                    state_next = S_TL;
                end
            end
        endcase
    end

    assign sel_next = ((state_next == S_TL) || (state_next == S_FORCE)) ? SEL_TL : SEL_DICE;

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register; dice_button can therefore never be high
    // while sel shows the traffic lights.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_reg         <= SEL_TL;
            dice_button_reg <= 1'b0;
            switch_reg      <= 1'b0;
        end else begin
            sel_reg         <= sel_next;
            dice_button_reg <= button_in && ((state_next == S_DICE) || (state_next == S_HOLD));
            switch_reg      <= (sel_next != sel_reg);
        end
    end

    assign sel         = sel_reg;
    assign dice_button = dice_button_reg;
    assign switch      = switch_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: a behavioural model pushes the
// expected outputs of every driven cycle into a queue; after the clock edge the
// entry is popped and compared against the DUT.
module tb_display_scheduler;

    localparam int TL_SLOT   = 16;
    localparam int DICE_SLOT = 8;
    localparam int HOLD      = 4;
    localparam int CW        = 8;

    localparam int ST_TL    = 0;
    localparam int ST_DICE  = 1;
    localparam int ST_HOLD  = 2;
    localparam int ST_FORCE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       button_in = 1'b0;
    logic       auto_en = 1'b0;
    logic       force_tl = 1'b0;
    logic       sel;
    logic       dice_button;
    logic       switch;
    logic [1:0] state;

    always #5 clk = ~clk;

    display_scheduler #(
        .TL_SLOT   (TL_SLOT),
        .DICE_SLOT (DICE_SLOT),
        .HOLD      (HOLD),
        .CW        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button_in   (button_in),
        .auto_en     (auto_en),
        .force_tl    (force_tl),
        .sel         (sel),
        .dice_button (dice_button),
        .switch      (switch),
        .state       (state)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       sel;
        logic       db;
        logic       sw;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // reference model state
    int   m_state = ST_TL;
    int   m_cnt   = 0;
    logic m_sel   = 1'b1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = ST_TL;
        m_cnt   = 0;
        m_sel   = 1'b1;
    endtask

    // One clock of the reference behaviour; pushes the expected registered outputs.
    task automatic model_step(input logic b, input logic a, input logic f);
        int   ns, nc;
        logic nsel;
        exp_t e;
        ns = m_state;
        nc = 0;
        case (m_state)
            ST_TL: begin
                if (f)                             ns = ST_FORCE;
                else if (b)                        ns = ST_HOLD;
                else if (a && m_cnt == TL_SLOT-1)  ns = ST_DICE;
                else if (a)                        nc = m_cnt + 1;
            end
            ST_DICE: begin
                if (f)                             ns = ST_FORCE;
                else if (b)                        ns = ST_HOLD;
                else if (!a)                       ns = ST_TL;
                else if (m_cnt == DICE_SLOT-1)     ns = ST_TL;
                else                               nc = m_cnt + 1;
            end
            ST_HOLD: begin
                if (f)                             ns = ST_FORCE;
                else if (b)                        ns = ST_HOLD;
                else if (m_cnt == HOLD-1)          ns = ST_TL;
                else                               nc = m_cnt + 1;
            end
            default: begin
                if (!f)                            ns = ST_TL;
            end
        endcase
        nsel  = (ns == ST_TL || ns == ST_FORCE);
        e.st  = 2'(ns);
        e.sel = nsel;
        e.db  = b && (ns == ST_DICE || ns == ST_HOLD);
        e.sw  = (nsel != m_sel);
        exp_q.push_back(e);
        m_state = ns;
        m_cnt   = nc;
        m_sel   = nsel;
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_empty_q"}, 8'd0, 8'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_state"}, {6'd0, state}, {6'd0, e.st});
        check({tag, "_sel"},   {7'd0, sel},   {7'd0, e.sel});
        check({tag, "_db"},    {7'd0, dice_button}, {7'd0, e.db});
        check({tag, "_sw"},    {7'd0, switch}, {7'd0, e.sw});
        check({tag, "_db_vs_sel"}, {7'd0, dice_button & sel}, 8'd0);
    endtask

    task automatic step(input logic b, input logic a, input logic f, input string tag);
        button_in = b;
        auto_en   = a;
        force_tl  = f;
        model_step(b, a, f);
        @(posedge clk);
        #1;
        cyc++;
        compare_head(tag);
        $display("cyc %0d %s b=%0b a=%0b f=%0b -> state=%0d sel=%0b db=%0b sw=%0b",
                 cyc, tag, b, a, f, state, sel, dice_button, switch);
    endtask

    // Advance with no button until the model reaches the wanted state/count.
    task automatic run_until(input int ts, input int tc, input logic a, input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_state == ts && (tc < 0 || m_cnt == tc)) begin
                found = 1;
                break;
            end
            step(1'b0, a, 1'b0, tag);
        end
        if (!found) check({tag, "_timeout"}, 8'd0, 8'd1);
    endtask

    task automatic check_reset_values(input string tag);
        exp_t e;
        e = '{st: 2'b00, sel: 1'b1, db: 1'b0, sw: 1'b0};
        exp_q.push_back(e);
        compare_head(tag);
        $display("%s: state=%0d sel=%0b db=%0b sw=%0b", tag, state, sel, dice_button, switch);
    endtask

    initial begin
        // reset held low across edges
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;
        model_reset();

        // 1: auto slicing, two full TL/DICE periods
        for (int i = 0; i < 2*(TL_SLOT+DICE_SLOT) + 2; i++) step(1'b0, 1'b1, 1'b0, "auto");

        // 2: button for 3 cycles starting at S_TL cnt=5, then the hold tail
        run_until(ST_TL, 5, 1'b1, "seek_tl5");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "press");
        for (int i = 0; i < HOLD + 4; i++) step(1'b0, 1'b1, 1'b0, "hold_tail");

        // 3: force_tl while holding the button in S_HOLD
        step(1'b1, 1'b1, 1'b0, "press2");
        step(1'b1, 1'b1, 1'b0, "press2");
        step(1'b1, 1'b1, 1'b1, "force_btn");
        step(1'b0, 1'b1, 1'b1, "force");
        step(1'b0, 1'b1, 1'b0, "unforce");
        step(1'b0, 1'b1, 1'b0, "unforce");

        // 4: manual mode stays on lights; then drop auto_en inside S_DICE
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0, "manual");
        run_until(ST_DICE, 2, 1'b1, "seek_dice");
        step(1'b0, 1'b0, 1'b0, "auto_drop");
        step(1'b0, 1'b0, 1'b0, "auto_drop");

        // 5: button on the expiry cycle of the TL slice
        run_until(ST_TL, TL_SLOT-1, 1'b1, "seek_tl15");
        step(1'b1, 1'b1, 1'b0, "press_expiry");
        for (int i = 0; i < HOLD + 2; i++) step(1'b0, 1'b1, 1'b0, "post_expiry");

        // 6: asynchronous reset between edges in S_DICE
        run_until(ST_DICE, 3, 1'b1, "seek_dice2");
        #3;
        rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int i = 0; i < TL_SLOT + DICE_SLOT + 2; i++) step(1'b0, 1'b1, 1'b0, "restart");

        // mixed random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 15) == 0), "rand");
        end

        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Controller that owns the `sel` input of the dice/traffic-light display multiplexer.
- Default view is traffic lights. In auto mode it time-slices the 3-bit display between traffic lights and dice.
- A button press pre-empts the display for the dice. The press is forwarded to the dice only while the dice is visible.
- `force_tl` locks the display on traffic lights.
- Sits between the board inputs (button, switches) and the mux top.

Parameters:
TL_SLOT, 16, cycles traffic lights are shown per auto slice (>=1)
DICE_SLOT, 8, cycles dice is shown per auto slice (>=1)
HOLD, 4, cycles dice stays shown after button release (>=1)
CW, 8, slot counter width; 2^CW must exceed max(TL_SLOT, DICE_SLOT, HOLD)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
button_in  in  1  roll request; synchronous to clk, debounced upstream
auto_en  in  1  1 = time-slice between views; 0 = traffic lights unless button
force_tl  in  1  override: show traffic lights, block dice
sel  out  1  mux select; 1 = traffic lights, 0 = dice
dice_button  out  1  gated button to dice roller
switch  out  1  one-cycle pulse on the cycle `sel` changes value
state  out  2  current FSM state, for debug/LEDs

Behaviour:
- All outputs and state are registered. rst low forces immediately, without a clock edge:
  - state = S_TL, cnt = 0
  - sel = 1, dice_button = 0, switch = 0
- States and `sel` values: S_TL (00, sel=1), S_DICE (01, sel=0), S_HOLD (10, sel=0), S_FORCE (11, sel=1).
- Priority each cycle: force_tl > button_in > slot expiry > auto_en drop.
- S_TL:
  - force_tl -> S_FORCE.
  - button_in -> S_HOLD, cnt=0.
  - auto_en and cnt==TL_SLOT-1 -> S_DICE, cnt=0.
  - auto_en otherwise: cnt++.
  - !auto_en: cnt held at 0.
- S_DICE:
  - force_tl -> S_FORCE.
  - button_in -> S_HOLD, cnt=0.
  - !auto_en -> S_TL next cycle, cnt=0.
  - cnt==DICE_SLOT-1 -> S_TL, cnt=0.
  - else cnt++.
- S_HOLD:
  - force_tl -> S_FORCE.
  - button_in: stay, cnt=0.
  - !button_in and cnt==HOLD-1 -> S_TL, cnt=0.
  - else cnt++.
  - The return is always to S_TL, regardless of auto_en.
- S_FORCE: stay while force_tl. On deassert -> S_TL, cnt=0.
- sel is registered from next state; latency is one clock from the input change.
- dice_button is registered as button_in AND (next state is S_DICE or S_HOLD).
  - A press that starts in S_TL asserts dice_button on the same edge that sel goes to 0.
  - dice_button is never high while sel=1.
- switch is registered (next sel != sel). It is never asserted out of reset.
- Slot expiry and button on the same cycle: button wins.
- force_tl asserted while button_in is high: dice_button drops on the next edge.

Decomposition:
- Package `display_pkg`: state encodings S_TL/S_DICE/S_HOLD/S_FORCE, SEL_TL=1 / SEL_DICE=0, default slot constants.
- One sub-module, `slot_timer`:
  - CW-bit counter with clear, enable and terminal compare against a runtime limit.
  - Outputs `done` when cnt==limit-1.
- The FSM stays in `display_scheduler`.

Test Plan:
1. Reset release, auto_en=1, no button -> sel=1 for 16 cycles, sel=0 for 8 cycles, repeating. switch pulses on each change; state cycles 00/01.
2. auto_en=1; button high 3 cycles starting at S_TL cnt=5:
   - sel=0 and dice_button=1 on the next edge; dice_button stays high 3 cycles.
   - sel stays 0 for 4 cycles after release, then 1 with cnt=0.
3. In S_HOLD with button high, assert force_tl -> next edge: sel=1, dice_button=0, state=11. Deassert -> state=00.
4. auto_en=0, no button for 100 cycles -> sel=1 constant, switch never pulses. In S_DICE, drop auto_en -> sel=1 after one edge.
5. Button asserted on the cycle S_TL cnt==15 -> state=10 (not 01) on the next edge; dice_button=1.
6. Pull rst low mid-S_DICE between clock edges -> sel=1, dice_button=0, state=00 immediately. Release -> TL slice restarts from cnt=0.
